// File: rtl/d_ff.sv
// Single-bit D flip-flop with an asynchronous active-high reset.
// This is the storage leaf cell that the width-parameterised register wrappers replicate once per bit.
`timescale 1ns/10ps

module d_ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Reset takes priority over a clock edge that arrives at the same moment, and clears q without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff. It runs directed scenarios first and then a randomised phase.
// A reference model checks q and three replicated instances on every cycle.
`timescale 1ns/10ps

module tb_d_ff;

  logic       clk;
  logic       reset;
  logic       d;
  logic       q;
  logic [2:0] d3;
  logic [2:0] q3;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model. q must equal the {d3,d} sampled at the last rising edge.
  // It must be 0 instead if reset was high at that edge or at any time since.
  logic [3:0] m_last_d;
  logic       m_last_rst;
  logic       m_rst_seen;
  logic       m_valid;

  d_ff dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  for (genvar g = 0; g < 3; g++) begin : g_rep
    d_ff u_rep (
      .clk   (clk),
      .reset (reset),
      .d     (d3[g]),
      .q     (q3[g])
    );
  end

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Capture the inputs the model needs at each rising clock edge.
  always @(posedge clk) begin
    m_last_d   = {d3, d};
    m_last_rst = reset;
    m_rst_seen = reset;
  end

  // Record reset pulses that arrive between clock edges.
  always @(posedge reset) begin
    m_rst_seen = 1'b1;
    m_valid    = 1'b1;
  end

  // Per-cycle comparison, 1 ns before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #49;
      if (m_valid) begin
        if (m_last_rst || m_rst_seen || reset) begin
          check("model_cycle", {q3, q}, 4'b0000);
        end else begin
          check("model_cycle", {q3, q}, m_last_d);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #10;
  endtask

  initial begin
    int unsigned sel;
    int unsigned off;
    int unsigned wid;
    n_vec      = 0;
    n_err      = 0;
    m_valid    = 1'b0;
    m_rst_seen = 1'b0;
    m_last_rst = 1'b0;
    m_last_d   = 4'b0000;
    reset      = 1'b0;
    d          = 1'b0;
    d3         = 3'b000;

    // Before any reset, q is X in a 4-state simulator.
    // A 2-state simulator may show 0 or 1 instead, so the value is only reported here.
    #10;
    $display("power-up q before any reset = %b", q);

    // Scenario 1: reset, then load 1, then load 0.
    next_cycle();
    reset = 1'b1;
    d     = 1'b0;
    #1 check("reset_async_clear", {3'b000, q}, 4'b0000);
    next_cycle();
    check("reset_held_edge", {3'b000, q}, 4'b0000);
    reset = 1'b0;
    d     = 1'b1;
    next_cycle();
    check("load_one", {3'b000, q}, 4'b0001);
    d = 1'b0;
    next_cycle();
    check("load_zero", {3'b000, q}, 4'b0000);

    // Scenario 2: hold d for two edges, then toggle d between edges.
    d = 1'b1;
    next_cycle();
    check("hold_cycle1", {3'b000, q}, 4'b0001);
    next_cycle();
    check("hold_cycle2", {3'b000, q}, 4'b0001);
    #15 d = 1'b0;
    #1 check("midcycle_d_low", {3'b000, q}, 4'b0001);
    #15 d = 1'b1;
    #1 check("midcycle_d_high", {3'b000, q}, 4'b0001);
    next_cycle();
    check("after_toggle_edge", {3'b000, q}, 4'b0001);

    // Scenario 3: raise reset 30 ns into a cycle while q is 1, then keep it high across three edges.
    #20 reset = 1'b1;
    #1 check("async_reset_instant", {3'b000, q}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("reset_beats_clk", {3'b000, q}, 4'b0000);
    end

    // Scenario 4: release reset mid-cycle with d=1.
    #30 reset = 1'b0;
    #1 check("release_no_load", {3'b000, q}, 4'b0000);
    next_cycle();
    check("release_first_edge", {3'b000, q}, 4'b0001);

    // Scenario 6: three replicated cells walk through every 3-bit pattern.
    reset = 1'b1;
    #5 reset = 1'b0;
    check("rep_after_reset", {q3, 1'b0}, 4'b0000);
    for (int p = 0; p < 8; p++) begin
      d3 = 3'(p);
      next_cycle();
      check("rep_pattern", {1'b0, q3}, 4'(p));
      next_cycle();
      check("rep_pattern_hold", {1'b0, q3}, 4'(p));
    end
    reset = 1'b1;
    #1 check("rep_final_reset", {q3, q}, 4'b0000);
    next_cycle();
    reset = 1'b0;

    // Randomised phase. Reset pulses land at arbitrary points within cycles, and d changes between edges.
    for (int i = 0; i < 300; i++) begin
      d   = 1'($urandom);
      d3  = 3'($urandom);
      sel = $urandom_range(0, 9);
      off = $urandom_range(1, 40);
      wid = $urandom_range(1, 40);
      if (sel == 0) begin
        #(off) reset = 1'b1;
        #(wid) reset = 1'b0;
      end else if (sel == 1) begin
        reset = 1'b1;
      end else if (reset) begin
        #(off) reset = 1'b0;
      end else begin
        #(off) d = 1'($urandom);
      end
      next_cycle();
    end

    reset = 1'b0;
    next_cycle();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
